// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM state
// encoding, default parameter values and a small width helper.
package wb_arb_pkg;

  localparam int DEF_NM      = 4;
  localparam int DEF_DWIDTH  = 32;
  localparam int DEF_AWIDTH  = 32;
  localparam int DEF_TIMEOUT = 16;

  // IDLE: no grant outstanding. OWNED: exactly one master holds the bus.
  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Width of an index into n masters; a single master still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Searches req upward starting one past
// last_owner (wrapping at NM) and returns the first hit as a one-hot vector.
// Implemented as rotate / isolate-lowest-bit / rotate-back so no search loop
// is needed.
module rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NM = DEF_NM,
  parameter int LW = idx_width(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last_owner,
  output logic [NM-1:0] pick
);

  localparam logic [LW-1:0] LAST_IDX = LW'(NM - 1);

  logic [LW-1:0]   start;
  logic [2*NM-1:0] rot_dbl;
  logic [2*NM-1:0] back_dbl;
  logic [NM-1:0]   rot;
  logic [NM-1:0]   first;

  // Rotate so the highest-priority master sits at bit 0, take the lowest
  // set bit, then rotate that bit back to its master position.
  // NOTE: combinational blocks use blocking '=' so each intermediate value
  // is visible to the next statement within the same evaluation.
  always_comb begin
    start    = (last_owner >= LAST_IDX) ? '0 : last_owner + LW'(1);
    rot_dbl  = {req, req} >> start;
    rot      = rot_dbl[NM-1:0];
    first    = rot & (~rot + NM'(1));
    back_dbl = {first, first} << start;
    pick     = back_dbl[2*NM-1:NM];
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Wishbone N-master to 1-slave round-robin arbiter with a slave-response
// watchdog. The grant is registered; the slave side is a combinational mux
// of the owning master, and terminations are routed back only to the owner.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NM      = DEF_NM,
  parameter int dwidth  = DEF_DWIDTH,
  parameter int awidth  = DEF_AWIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NM-1:0]              m_cyc,
  input  logic [NM-1:0]              m_stb,
  input  logic [NM-1:0]              m_we,
  input  logic [NM*awidth-1:0]       m_adr,
  input  logic [NM*dwidth-1:0]       m_dat_i,
  input  logic [NM*(dwidth/8)-1:0]   m_sel,
  output logic [dwidth-1:0]          m_dat_o,
  output logic [NM-1:0]              m_ack,
  output logic [NM-1:0]              m_err,
  output logic [NM-1:0]              m_rty,
  output logic                       s_cyc,
  output logic                       s_stb,
  output logic                       s_we,
  output logic [awidth-1:0]          s_adr,
  output logic [dwidth-1:0]          s_dat_o,
  output logic [dwidth/8-1:0]        s_sel,
  input  logic [dwidth-1:0]          s_dat_i,
  input  logic                       s_ack,
  input  logic                       s_err,
  input  logic                       s_rty,
  output logic [NM-1:0]              gnt
);

  localparam int LW = idx_width(NM);
  localparam int SW = dwidth / 8;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  arb_state_e    state_q, state_d;
  logic [NM-1:0] gnt_q, gnt_d;
  logic [LW-1:0] last_owner_q, last_owner_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic [NM-1:0]     pick;
  logic [LW-1:0]     owner_idx;
  logic              owner_cyc;
  logic              owner_stb;
  logic              owner_we;
  logic [awidth-1:0] owner_adr;
  logic [dwidth-1:0] owner_dat;
  logic [SW-1:0]     owner_sel;
  logic              timeout_hit;

  rr_pick #(
    .NM (NM),
    .LW (LW)
  ) u_rr_pick (
    .req        (m_cyc),
    .last_owner (last_owner_q),
    .pick       (pick)
  );

  // State, grant, round-robin pointer and watchdog registers.
  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      last_owner_q <= LW'(NM - 1);
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      wdog_q       <= wdog_d;
    end
  end

  // Select the owner's request fields; an all-zero grant yields all-zero fields.
  // NOTE: every output gets a default before the loop, otherwise a master
  // with no grant bit would leave the value held and infer a latch.
  always_comb begin
    owner_idx = '0;
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    owner_we  = 1'b0;
    owner_adr = '0;
    owner_dat = '0;
    owner_sel = '0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q[i]) begin
        owner_idx = LW'(i);
        owner_cyc = m_cyc[i];
        owner_stb = m_stb[i];
        owner_we  = m_we[i];
        owner_adr = m_adr[i*awidth +: awidth];
        owner_dat = m_dat_i[i*dwidth +: dwidth];
        owner_sel = m_sel[i*SW +: SW];
      end
    end
  end

  // Arbitration FSM: grant on any request from IDLE, release when the
  // owner drops cyc. Releasing always passes through IDLE for one cycle.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (|m_cyc) begin
          state_d = OWNED;
          gnt_d   = pick;
        end
      end
      OWNED: begin
        if (!owner_cyc) begin
          state_d      = IDLE;
          gnt_d        = '0;
          last_owner_d = owner_idx;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign timeout_hit = (state_q == OWNED) && (wdog_q == WD_LIMIT);

  // Watchdog counts consecutive stalled strobe cycles; any termination,
  // idle bus, release or the timeout itself restarts it from zero.
  always_comb begin
    wdog_d = '0;
    if ((state_q == OWNED) && owner_cyc && owner_stb && !timeout_hit &&
        !s_ack && !s_err && !s_rty) begin
      wdog_d = wdog_q + WW'(1);
    end
  end

  // Slave side: owner's request, with the strobe withdrawn on a timeout.
  assign s_cyc   = owner_cyc;
  assign s_stb   = owner_stb & ~timeout_hit;
  assign s_we    = owner_we;
  assign s_adr   = owner_adr;
  assign s_dat_o = owner_dat;
  assign s_sel   = owner_sel;

  // Master side: terminations only reach the granted master; the watchdog
  // reports a timeout as an error to the owner.
  assign m_dat_o = s_dat_i;
  assign m_ack   = {NM{s_ack}} & gnt_q;
  assign m_err   = {NM{s_err | timeout_hit}} & gnt_q;
  assign m_rty   = {NM{s_rty}} & gnt_q;
  assign gnt     = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with a cycle-level reference model of
// the arbitration rules and a per-cycle compare process.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic              clk;
  logic              rst;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat_i;
  logic [NM*SW-1:0]  m_sel;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack, m_err, m_rty;
  logic              s_cyc, s_stb, s_we;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack, s_err, s_rty;
  logic [NM-1:0]     gnt;

  int vectors     = 0;
  int miscompares = 0;

  wb_rr_arbiter #(
    .NM      (NM),
    .dwidth  (DW),
    .awidth  (AW),
    .TIMEOUT (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat_i (m_dat_i),
    .m_sel   (m_sel),
    .m_dat_o (m_dat_o),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .m_rty   (m_rty),
    .s_cyc   (s_cyc),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_adr   (s_adr),
    .s_dat_o (s_dat_o),
    .s_sel   (s_sel),
    .s_dat_i (s_dat_i),
    .s_ack   (s_ack),
    .s_err   (s_err),
    .s_rty   (s_rty),
    .gnt     (gnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Owner is -1 when the bus is free; stall counts consecutive cycles the
  // owner strobed without any slave termination.
  int mdl_owner;
  int mdl_last;
  int mdl_stall;
  int mdl_c;
  bit mdl_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mdl_owner = -1;
      mdl_last  = NM - 1;
      mdl_stall = 0;
      mdl_valid = 1'b1;
    end else if (mdl_valid) begin
      if (mdl_owner < 0) begin
        for (int k = 1; k <= NM; k++) begin
          mdl_c = (mdl_last + k) % NM;
          if (mdl_owner < 0 && m_cyc[mdl_c]) mdl_owner = mdl_c;
        end
        mdl_stall = 0;
      end else if (!m_cyc[mdl_owner]) begin
        mdl_last  = mdl_owner;
        mdl_owner = -1;
        mdl_stall = 0;
      end else if (mdl_stall == TO) begin
        mdl_stall = 0;
      end else if (m_stb[mdl_owner] && !s_ack && !s_err && !s_rty) begin
        mdl_stall++;
      end else begin
        mdl_stall = 0;
      end
    end
  end

  logic [NM-1:0] e_gnt;
  logic          e_hit, e_cyc, e_stb, e_we;
  logic [AW-1:0] e_adr;
  logic [DW-1:0] e_dat;
  logic [SW-1:0] e_sel;

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (mdl_valid) begin
      e_gnt = '0;
      e_hit = 1'b0;
      e_cyc = 1'b0;
      e_stb = 1'b0;
      e_we  = 1'b0;
      e_adr = '0;
      e_dat = '0;
      e_sel = '0;
      if (mdl_owner >= 0) begin
        e_gnt[mdl_owner] = 1'b1;
        e_hit = (mdl_stall == TO);
        e_cyc = m_cyc[mdl_owner];
        e_stb = m_stb[mdl_owner] && !e_hit;
        e_we  = m_we[mdl_owner];
        e_adr = m_adr[mdl_owner*AW +: AW];
        e_dat = m_dat_i[mdl_owner*DW +: DW];
        e_sel = m_sel[mdl_owner*SW +: SW];
      end
      check("mdl_gnt",     64'(gnt),     64'(e_gnt));
      check("mdl_s_cyc",   64'(s_cyc),   64'(e_cyc));
      check("mdl_s_stb",   64'(s_stb),   64'(e_stb));
      check("mdl_s_we",    64'(s_we),    64'(e_we));
      check("mdl_s_adr",   64'(s_adr),   64'(e_adr));
      check("mdl_s_dat_o", 64'(s_dat_o), 64'(e_dat));
      check("mdl_s_sel",   64'(s_sel),   64'(e_sel));
      check("mdl_m_ack",   64'(m_ack),   64'(s_ack ? e_gnt : '0));
      check("mdl_m_err",   64'(m_err),   64'((s_err || e_hit) ? e_gnt : '0));
      check("mdl_m_rty",   64'(m_rty),   64'(s_rty ? e_gnt : '0));
      check("mdl_m_dat_o", 64'(m_dat_o), 64'(s_dat_i));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel);
    m_cyc[i]             = cyc;
    m_stb[i]             = stb;
    m_we[i]              = we;
    m_adr[i*AW +: AW]    = adr;
    m_dat_i[i*DW +: DW]  = dat;
    m_sel[i*SW +: SW]    = sel;
  endtask

  task automatic req_on(input int i);
    set_m(i, 1'b1, 1'b1, 1'b0, AW'(32'h100 << i), DW'(32'hC0DE_0000 + i), SW'(4'b0001 << i));
  endtask

  task automatic req_off(input int i);
    set_m(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic clear_all();
    for (int i = 0; i < NM; i++) req_off(i);
  endtask

  // Drive inputs 2 ns after a falling edge; outputs are read at falling edges.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    clear_all();
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    @(negedge clk);
    check("rst_gnt",   64'(gnt),   64'h0);
    check("rst_s_cyc", 64'(s_cyc), 64'h0);
    check("rst_s_stb", 64'(s_stb), 64'h0);
    #2;
    rst = 1'b0;
  endtask

  int rr_idx [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst     = 1'b1;
    m_cyc   = '0;
    m_stb   = '0;
    m_we    = '0;
    m_adr   = '0;
    m_dat_i = '0;
    m_sel   = '0;
    s_dat_i = 32'h1234_5678;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_rty   = 1'b0;

    // Single request from master 2 with an acking slave.
    do_reset();
    s_ack = 1'b1;
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF);
    @(negedge clk);
    check("single_gnt",   64'(gnt),     64'h4);
    check("single_adr",   64'(s_adr),   64'h10);
    check("single_dat",   64'(s_dat_o), 64'hA5A5_A5A5);
    check("single_we",    64'(s_we),    64'h1);
    check("single_ack",   64'(m_ack),   64'h4);
    check("single_mdat",  64'(m_dat_o), 64'h1234_5678);
    #2 req_off(2);
    @(negedge clk);
    check("single_rel_gnt", 64'(gnt),   64'h0);
    check("single_late_ack", 64'(m_ack), 64'h0);

    // Fairness: all four request continuously, each releases after one ack.
    do_reset();
    s_ack = 1'b1;
    for (int i = 0; i < NM; i++) req_on(i);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("rr_grant", 64'(gnt), 64'(1) << rr_idx[n]);
      #2 req_off(rr_idx[n]);
      @(negedge clk);
      check("rr_idle", 64'(gnt), 64'h0);
      #2 req_on(rr_idx[n]);
    end
    #0 clear_all();

    // Contention: master 1 owns; 3 waits; 2 withdraws before it is served.
    do_reset();
    s_ack   = 1'b1;
    s_dat_i = 32'h0BAD_F00D;
    req_on(1);
    @(negedge clk);
    check("cont_own1", 64'(gnt), 64'h2);
    #2;
    req_on(3);
    req_on(2);
    repeat (2) begin
      @(negedge clk);
      check("cont_hold", 64'(gnt), 64'h2);
    end
    #2 req_off(2);
    repeat (2) begin
      @(negedge clk);
      check("cont_hold2", 64'(gnt), 64'h2);
    end
    #2 req_off(1);
    @(negedge clk);
    check("cont_idle", 64'(gnt), 64'h0);
    @(negedge clk);
    check("cont_own3", 64'(gnt),   64'h8);
    check("cont_adr3", 64'(s_adr), 64'h800);
    #2;
    s_ack = 1'b0;
    s_rty = 1'b1;
    @(negedge clk);
    check("cont_rty3", 64'(m_rty), 64'h8);
    check("cont_ack3", 64'(m_ack), 64'h0);
    #2;
    s_rty = 1'b0;
    req_off(3);

    // Watchdog: slave never responds to master 0.
    do_reset();
    req_on(0);
    @(negedge clk);
    check("wd_stb_up", 64'(s_stb), 64'h1);
    check("wd_err0",   64'(m_err), 64'h0);
    for (int c = 1; c < TO; c++) begin
      @(negedge clk);
      check("wd_quiet", 64'(m_err), 64'h0);
    end
    @(negedge clk);
    check("wd_err",     64'(m_err), 64'h1);
    check("wd_stb_low", 64'(s_stb), 64'h0);
    @(negedge clk);
    check("wd_pulse_end", 64'(m_err), 64'h0);
    check("wd_stb_back",  64'(s_stb), 64'h1);
    #2 req_off(0);
    @(negedge clk);
    check("wd_rel", 64'(gnt), 64'h0);

    // Reset in the middle of a transfer, then a full request set.
    do_reset();
    req_on(2);
    @(negedge clk);
    check("mid_own2", 64'(gnt), 64'h4);
    @(negedge clk);
    check("mid_stb", 64'(s_stb), 64'h1);
    #2;
    rst = 1'b1;
    for (int i = 0; i < NM; i++) req_on(i);
    @(negedge clk);
    check("mid_rst_gnt",   64'(gnt),   64'h0);
    check("mid_rst_s_cyc", 64'(s_cyc), 64'h0);
    check("mid_rst_s_stb", 64'(s_stb), 64'h0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("mid_after_gnt", 64'(gnt), 64'h1);
    #2 clear_all();
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
